mdu_unit: RTL and testbench

- Multi-cycle multiply/divide unit with HI/LO registers, for the pipelined MIPS core's execute stage.
- Consumes the two GRF read operands alongside the ALU.
- Its read result goes to the register write-data mux for mfhi/mflo.
- Raises busy so the hazard logic can stall any later mult/div/mf/mt instruction.

---
 rtl/mdu_pkg.sv | 27 ++
 rtl/mdu_unit.sv | 112 +++++++++++
 tb/tb_mdu_unit.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared operation encodings, default latencies and FSM state type for the multiply/divide unit.
// Imported by the MDU itself and by the hazard logic that stalls on busy.
package mdu_pkg;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } mdu_state_t;

    function automatic logic is_long_op(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers; latency MULT_CYCLES / DIV_CYCLES from accept.
// Backpressure: busy is high while an op is in flight; new ops other than MFHI/MFLO are dropped.
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd
);

    mdu_state_t  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  op_q;
    logic [31:0] a_q, b_q;
    logic        latch_en;
    logic        done;

    logic [63:0] prod_s, prod_u;
    logic [31:0] div_b, quot_s, rem_s, quot_u, rem_u;
    logic        div_ovf;

    assign busy = (state_q == S_RUN);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        latch_en = 1'b0;
        done     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && is_long_op(op)) begin
                    latch_en = 1'b1;
                    state_d  = S_RUN;
                    cnt_d    = ((op == OP_MULT) || (op == OP_MULTU)) ? 4'(MULT_CYCLES)
                                                                      : 4'(DIV_CYCLES);
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_NONE;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch_en) begin
                op_q <= op;
                a_q  <= a;
                b_q  <= b;
            end
        end
    end

    assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};

    // Divisor forced non-zero so the datapath never divides by zero; the result is discarded anyway.
    assign div_b   = (b_q == 32'd0) ? 32'd1 : b_q;
    assign div_ovf = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
    assign quot_s  = div_ovf ? 32'h8000_0000 : 32'($signed(a_q) / $signed(div_b));
    assign rem_s   = div_ovf ? 32'd0         : 32'($signed(a_q) % $signed(div_b));
    assign quot_u  = a_q / div_b;
    assign rem_u   = a_q % div_b;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi <= '0;
            lo <= '0;
        end else if (done) begin
            case (op_q)
                OP_MULT:  {hi, lo} <= prod_s;
                OP_MULTU: {hi, lo} <= prod_u;
                OP_DIV:   if (b_q != 32'd0) begin hi <= rem_s; lo <= quot_s; end
                OP_DIVU:  if (b_q != 32'd0) begin hi <= rem_u; lo <= quot_u; end
                default: ;
            endcase
        end else if (state_q == S_IDLE && start) begin
            if (op == OP_MTHI) hi <= a;
            if (op == OP_MTLO) lo <= a;
        end
    end

    always_comb begin
        rd = '0;
        if (op == OP_MFHI) rd = hi;
        else if (op == OP_MFLO) rd = lo;
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit: expected HI/LO and busy length are queued at issue,
// a negedge monitor checks them when busy falls.
module tb_mdu_unit;
    import mdu_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  op = OP_NONE;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic [31:0] hi, lo, rd;

    int n_cmp = 0;
    int n_err = 0;
    exp_t exp_q[$];

    mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .hi(hi), .lo(lo), .rd(rd)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
        end
    endtask

    task automatic issue(input logic [3:0] o, input logic [31:0] va, input logic [31:0] vb);
        start = 1'b1; op = o; a = va; b = vb;
        @(posedge clk); #1;
        start = 1'b0; op = OP_NONE; a = 32'hDEAD_BEEF; b = 32'hDEAD_BEEF;
    endtask

    task automatic push(input string name, input logic [31:0] h, input logic [31:0] l, input int c);
        exp_t e;
        e.name = name; e.hi = h; e.lo = l; e.cycles = c;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        int i;
        for (i = 0; i < 50 && busy; i++) @(negedge clk);
        if (busy) check({name, "_timeout"}, 32'(busy), 32'd0);
    endtask

    // Monitor: counts busy cycles and scores each completion against the queue.
    initial begin
        int  busy_cnt;
        logic prev_busy;
        exp_t e;
        busy_cnt = 0;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                busy_cnt = 0;
                prev_busy = 1'b0;
            end else begin
                if (busy) busy_cnt++;
                if (prev_busy && !busy) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_completion", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check({e.name, "_hi"}, hi, e.hi);
                        check({e.name, "_lo"}, lo, e.lo);
                        check({e.name, "_busy_cycles"}, 32'(busy_cnt), 32'(e.cycles));
                    end
                    busy_cnt = 0;
                end
                prev_busy = busy;
            end
        end
    end

    initial begin
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        push("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
        issue(OP_MULT, 32'hFFFF_FFFE, 32'd3);
        wait_idle("mult");

        push("multu", 32'h0000_0002, 32'hFFFF_FFFA, 5);
        issue(OP_MULTU, 32'hFFFF_FFFE, 32'd3);
        wait_idle("multu");

        push("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_idle("div");

        push("divu", 32'd1, 32'd3, 10);
        issue(OP_DIVU, 32'd7, 32'd2);
        wait_idle("divu");

        issue(OP_MTHI, 32'h11, 32'd0);
        check("mthi_hi", hi, 32'h11);
        check("mthi_busy", 32'(busy), 32'd0);
        issue(OP_MTLO, 32'h22, 32'd0);
        check("mtlo_lo", lo, 32'h22);
        op = OP_MFHI; #1;
        check("mfhi_idle_rd", rd, 32'h11);
        op = OP_NONE; #1;
        check("rd_none", rd, 32'd0);

        push("div_by_zero", 32'h11, 32'h22, 10);
        issue(OP_DIV, 32'd100, 32'd0);
        wait_idle("div_by_zero");

        push("div_ovf", 32'd0, 32'h8000_0000, 10);
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle("div_ovf");

        push("mult_busy", 32'd0, 32'd6, 5);
        issue(OP_MULT, 32'd2, 32'd3);
        issue(OP_MTLO, 32'h55, 32'd0);
        issue(OP_MULT, 32'd7, 32'd7);
        op = OP_MFLO; start = 1'b1; #1;
        check("mflo_busy_rd", rd, 32'h8000_0000);
        start = 1'b0; op = OP_NONE;
        wait_idle("mult_busy");

        push("mult_back2back", 32'd0, 32'd20, 5);
        issue(OP_MULT, 32'd4, 32'd5);
        wait_idle("mult_back2back");

        issue(OP_DIV, 32'd100, 32'd7);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0; #1;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_hi", hi, 32'd0);
        check("rst_mid_lo", lo, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_hi", hi, 32'd0);
        check("post_rst_lo", lo, 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
